// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the UART word-guess game.
// Latches the secret word, takes guess letters from the UART receive buffer,
// scores them against the word, and drives the round status LEDs.
//
// Handshake: ready is a level "msg valid" flag with no backpressure. One
// rising edge of ready is one guess, sampled together with msg on that clock.
// Edges that arrive outside WAIT_GUESS are dropped, not queued. A ready held
// high for many cycles still counts as one guess.
//
// state_dbg encoding: 0 IDLE, 1 WAIT_GUESS, 2 CHECK, 3 SHOW, 4 WIN, 5 LOSS.
module game_round_ctrl #(
  parameter int MAX_MISS    = 6,
  parameter int BUSY_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [39:0] setWord,
  input  logic        toggle_state,
  input  logic        gameEnd_host,
  input  logic [7:0]  msg,
  input  logic        ready,
  output logic [7:0]  letter,
  output logic [4:0]  indexCorrect,
  output logic [2:0]  correct,
  output logic [2:0]  incorrect,
  output logic        mistake,
  output logic        red_busy,
  output logic        err_LED,
  output logic        blue,
  output logic        green,
  output logic        red,
  output logic [2:0]  state_dbg
);

  localparam int             CW        = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0]  BUSY_LOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [2:0]     MISS_MAX  = 3'(MAX_MISS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CHECK = 3'd2,
    S_SHOW  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSS  = 3'd5
  } state_t;

  state_t        state;
  logic [39:0]   word_r;
  logic [25:0]   used;
  logic [CW-1:0] busy_cnt;
  logic          ready_q;
  logic          tog_q;

  logic          ready_rise;
  logic          tog_rise;
  logic          start_round;
  logic          msg_valid;
  logic [4:0]    letter_idx;
  logic          msg_dup;
  logic [4:0]    hit;

  assign ready_rise = ready & ~ready_q;
  assign tog_rise   = toggle_state & ~tog_q;
  assign state_dbg  = state;

  // Revealed-position count; the only unregistered output.
  assign correct = {2'b00, indexCorrect[0]} + {2'b00, indexCorrect[1]} +
                   {2'b00, indexCorrect[2]} + {2'b00, indexCorrect[3]} +
                   {2'b00, indexCorrect[4]};

  // Guess classification and per-position match against the latched word.
  always_comb begin
    start_round = 1'b0;
    msg_valid   = (msg >= 8'h41) && (msg <= 8'h5A);
    // For 'A'..'Z' the low five bits run 1..26, so subtract one for the slot.
    letter_idx  = msg[4:0] - 5'd1;
    msg_dup     = msg_valid && used[letter_idx];
    for (int i = 0; i < 5; i++) begin
      hit[i] = (word_r[8*i +: 8] == letter);
    end
    // A restart is honoured everywhere except while a guess is being scored.
    if (tog_rise && (state != S_CHECK) && (state != S_SHOW)) begin
      start_round = 1'b1;
    end
  end

  // Round FSM with registered LED outputs; abort beats restart beats guesses.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= S_IDLE;
      word_r       <= '0;
      used         <= '0;
      busy_cnt     <= '0;
      ready_q      <= 1'b0;
      tog_q        <= 1'b0;
      letter       <= '0;
      indexCorrect <= '0;
      incorrect    <= '0;
      mistake      <= 1'b0;
      red_busy     <= 1'b0;
      err_LED      <= 1'b0;
      blue         <= 1'b0;
      green        <= 1'b0;
      red          <= 1'b0;
    end else begin
      ready_q <= ready;
      tog_q   <= toggle_state;
      if (gameEnd_host) begin
        state        <= S_IDLE;
        word_r       <= '0;
        used         <= '0;
        busy_cnt     <= '0;
        letter       <= '0;
        indexCorrect <= '0;
        incorrect    <= '0;
        mistake      <= 1'b0;
        red_busy     <= 1'b0;
        err_LED      <= 1'b0;
        blue         <= 1'b0;
        green        <= 1'b0;
        red          <= 1'b0;
      end else if (start_round) begin
        state        <= S_WAIT;
        word_r       <= setWord;
        used         <= '0;
        busy_cnt     <= '0;
        letter       <= '0;
        indexCorrect <= '0;
        incorrect    <= '0;
        mistake      <= 1'b0;
        red_busy     <= 1'b0;
        err_LED      <= 1'b0;
        blue         <= 1'b1;
        green        <= 1'b0;
        red          <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (ready_rise) begin
              if (!msg_valid || msg_dup) begin
                err_LED <= 1'b1;
              end else begin
                letter   <= msg;
                used     <= used | (26'd1 << letter_idx);
                err_LED  <= 1'b0;
                red_busy <= 1'b1;
                state    <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            indexCorrect <= indexCorrect | hit;
            if (hit == 5'b00000) begin
              mistake <= 1'b1;
              if (incorrect != MISS_MAX) begin
                incorrect <= incorrect + 3'd1;
              end
            end else begin
              mistake <= 1'b0;
            end
            busy_cnt <= BUSY_LOAD;
            state    <= S_SHOW;
          end
          S_SHOW: begin
            if (busy_cnt == '0) begin
              red_busy <= 1'b0;
              if (&indexCorrect) begin
                blue  <= 1'b0;
                green <= 1'b1;
                state <= S_WIN;
              end else if (incorrect == MISS_MAX) begin
                blue  <= 1'b0;
                red   <= 1'b1;
                state <= S_LOSS;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              busy_cnt <= busy_cnt - 1'b1;
            end
          end
          default: begin
            // IDLE, WIN and LOSS hold until a restart or an abort.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: table vectors, hand-written corner sequences and a
// randomized run against a letter-level model of the word-guess round.
module tb_game_round_ctrl;

  localparam int MAXM = 6;
  localparam int BUSY = 20;
  localparam logic [39:0] W_MOORE = 40'h4D4F4F5245;
  localparam logic [39:0] W_YUMMY = 40'h59554D4D59;

  logic        tb_clk;
  logic        nRst;
  logic [39:0] setWord;
  logic        toggle_state;
  logic        gameEnd_host;
  logic [7:0]  msg;
  logic        ready;
  logic [7:0]  letter;
  logic [4:0]  indexCorrect;
  logic [2:0]  correct;
  logic [2:0]  incorrect;
  logic        mistake;
  logic        red_busy;
  logic        err_LED;
  logic        blue;
  logic        green;
  logic        red;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  game_round_ctrl #(.MAX_MISS(MAXM), .BUSY_CYCLES(BUSY)) dut (
    .clk(tb_clk), .nRst(nRst), .setWord(setWord), .toggle_state(toggle_state),
    .gameEnd_host(gameEnd_host), .msg(msg), .ready(ready), .letter(letter),
    .indexCorrect(indexCorrect), .correct(correct), .incorrect(incorrect),
    .mistake(mistake), .red_busy(red_busy), .err_LED(err_LED), .blue(blue),
    .green(green), .red(red), .state_dbg(state_dbg)
  );

  // Clock
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, field, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] ic,
                           input logic [2:0] inc, input bit mis, input bit err,
                           input bit grn, input bit rd, input bit blu,
                           input logic [7:0] let_, input int busy_exp,
                           input int busy_act);
    chk(tag, "indexCorrect", indexCorrect, ic);
    chk(tag, "correct", correct, $countones(ic));
    chk(tag, "incorrect", incorrect, inc);
    chk(tag, "mistake", mistake, mis);
    chk(tag, "err_LED", err_LED, err);
    chk(tag, "green", green, grn);
    chk(tag, "red", red, rd);
    chk(tag, "blue", blue, blu);
    chk(tag, "letter", letter, let_);
    chk(tag, "busy_cycles", busy_act, busy_exp);
  endtask

  task automatic check_zero(input string tag);
    check_all(tag, 5'b0, 3'd0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    chk(tag, "red_busy", red_busy, 0);
    chk(tag, "state", state_dbg, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_round(input logic [39:0] w);
    @(negedge tb_clk);
    setWord = w;
    toggle_state = 1'b1;
    @(negedge tb_clk);
    toggle_state = 1'b0;
  endtask

  // One guess: ready high for 'hold' cycles, then watch the whole busy window.
  task automatic guess(input logic [7:0] m, input int hold, output int busy_n);
    @(negedge tb_clk);
    msg = m;
    ready = 1'b1;
    busy_n = 0;
    for (int c = 0; c < BUSY + 6; c++) begin
      @(negedge tb_clk);
      if (c == hold - 1) ready = 1'b0;
      if (red_busy) busy_n++;
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mw[5];
  bit         rev[5];
  bit         mused[26];
  int         mmiss;
  bit         merr, mmis, mwin, mloss;
  logic [7:0] mlet;

  task automatic model_start(input logic [39:0] w);
    for (int i = 0; i < 5; i++) begin
      mw[i] = w[8*i +: 8];
      rev[i] = 0;
    end
    for (int i = 0; i < 26; i++) mused[i] = 0;
    mmiss = 0; merr = 0; mmis = 0; mwin = 0; mloss = 0; mlet = 8'h00;
  endtask

  task automatic model_guess(input logic [7:0] m, output int busy_exp);
    bit any;
    bit all;
    busy_exp = 0;
    if (mwin || mloss) return;
    if (m < "A" || m > "Z") begin
      merr = 1;
    end else if (mused[int'(m) - 65]) begin
      merr = 1;
    end else begin
      mused[int'(m) - 65] = 1;
      mlet = m;
      merr = 0;
      any = 0;
      for (int i = 0; i < 5; i++) begin
        if (mw[i] == m) begin
          rev[i] = 1;
          any = 1;
        end
      end
      mmis = !any;
      if (!any && mmiss < MAXM) mmiss++;
      busy_exp = BUSY + 1;
      all = 1;
      for (int i = 0; i < 5; i++) if (!rev[i]) all = 0;
      if (all) mwin = 1;
      else if (mmiss == MAXM) mloss = 1;
    end
  endtask

  function automatic logic [4:0] model_ic();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = rev[i];
    return v;
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    bit          start;
    logic [39:0] word;
    logic [7:0]  m;
    logic [4:0]  ic;
    logic [2:0]  inc;
    bit          mis;
    bit          err;
    bit          grn;
    bit          rd;
    bit          blu;
    logic [7:0]  let_;
    int          busy;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    int b;
    int be;
    logic [39:0] w;
    logic [7:0] m;

    vecs[0]  = '{1, W_MOORE, "O",   5'b01100, 3'd0, 0, 0, 0, 0, 1, "O", BUSY+1};
    vecs[1]  = '{0, W_MOORE, "P",   5'b01100, 3'd1, 1, 0, 0, 0, 1, "P", BUSY+1};
    vecs[2]  = '{0, W_MOORE, "M",   5'b11100, 3'd1, 0, 0, 0, 0, 1, "M", BUSY+1};
    vecs[3]  = '{0, W_MOORE, "M",   5'b11100, 3'd1, 0, 1, 0, 0, 1, "M", 0};
    vecs[4]  = '{0, W_MOORE, "R",   5'b11110, 3'd1, 0, 0, 0, 0, 1, "R", BUSY+1};
    vecs[5]  = '{0, W_MOORE, "E",   5'b11111, 3'd1, 0, 0, 1, 0, 0, "E", BUSY+1};
    vecs[6]  = '{0, W_MOORE, "A",   5'b11111, 3'd1, 0, 0, 1, 0, 0, "E", 0};
    vecs[7]  = '{1, W_MOORE, 8'h31, 5'b00000, 3'd0, 0, 1, 0, 0, 1, 8'h00, 0};
    vecs[8]  = '{0, W_MOORE, 8'h61, 5'b00000, 3'd0, 0, 1, 0, 0, 1, 8'h00, 0};
    vecs[9]  = '{0, W_MOORE, "O",   5'b01100, 3'd0, 0, 0, 0, 0, 1, "O", BUSY+1};
    vecs[10] = '{1, W_YUMMY, "I",   5'b00000, 3'd1, 1, 0, 0, 0, 1, "I", BUSY+1};
    vecs[11] = '{0, W_YUMMY, "L",   5'b00000, 3'd2, 1, 0, 0, 0, 1, "L", BUSY+1};
    vecs[12] = '{0, W_YUMMY, "K",   5'b00000, 3'd3, 1, 0, 0, 0, 1, "K", BUSY+1};
    vecs[13] = '{0, W_YUMMY, "N",   5'b00000, 3'd4, 1, 0, 0, 0, 1, "N", BUSY+1};
    vecs[14] = '{0, W_YUMMY, "J",   5'b00000, 3'd5, 1, 0, 0, 0, 1, "J", BUSY+1};
    vecs[15] = '{0, W_YUMMY, "F",   5'b00000, 3'd6, 1, 0, 0, 1, 0, "F", BUSY+1};
    vecs[16] = '{0, W_YUMMY, "Y",   5'b00000, 3'd6, 1, 0, 0, 1, 0, "F", 0};

    nRst = 1'b0; setWord = '0; toggle_state = 1'b0; gameEnd_host = 1'b0;
    msg = 8'h00; ready = 1'b0;
    repeat (2) @(negedge tb_clk);
    check_zero("reset");
    nRst = 1'b1;
    @(negedge tb_clk);
    check_zero("post_reset");

    // Table-driven rounds: win on MOORE, invalid bytes, loss on YUMMY.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].start) start_round(vecs[i].word);
      guess(vecs[i].m, 1, b);
      check_all($sformatf("vec%0d", i), vecs[i].ic, vecs[i].inc, vecs[i].mis,
                vecs[i].err, vecs[i].grn, vecs[i].rd, vecs[i].blu, vecs[i].let_,
                vecs[i].busy, b);
    end

    // Reset mid-round after two guesses; nRst low for one cycle.
    start_round(W_MOORE);
    guess("O", 1, b);
    guess("P", 1, b);
    @(negedge tb_clk);
    nRst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge tb_clk);
    nRst = 1'b1;
    @(negedge tb_clk);
    check_zero("rst_release");
    guess("O", 1, b);
    check_zero("guess_in_idle");
    chk("guess_in_idle", "busy_cycles", b, 0);

    // Ready held ten cycles plus a second pulse during SHOW: one guess only.
    start_round(W_MOORE);
    @(negedge tb_clk);
    msg = "O";
    ready = 1'b1;
    b = 0;
    for (int c = 0; c < BUSY + 8; c++) begin
      @(negedge tb_clk);
      if (c == 9) ready = 1'b0;
      if (c == 14) begin
        msg = "E";
        ready = 1'b1;
      end
      if (c == 15) ready = 1'b0;
      if (red_busy) b++;
    end
    check_all("held_ready", 5'b01100, 3'd0, 0, 0, 0, 0, 1, "O", BUSY+1, b);
    chk("held_ready", "state", state_dbg, 1);

    // Abort in SHOW clears everything on the next edge.
    start_round(W_MOORE);
    @(negedge tb_clk);
    msg = "P";
    ready = 1'b1;
    @(negedge tb_clk);
    ready = 1'b0;
    repeat (4) @(negedge tb_clk);
    chk("abort_pre", "red_busy", red_busy, 1);
    gameEnd_host = 1'b1;
    @(negedge tb_clk);
    gameEnd_host = 1'b0;
    check_zero("abort");

    // Restart and guess on the same edge: restart wins, guess dropped.
    start_round(W_MOORE);
    guess("O", 1, b);
    @(negedge tb_clk);
    setWord = W_YUMMY;
    toggle_state = 1'b1;
    msg = "Y";
    ready = 1'b1;
    @(negedge tb_clk);
    toggle_state = 1'b0;
    ready = 1'b0;
    b = 0;
    for (int c = 0; c < 4; c++) begin
      if (red_busy) b++;
      @(negedge tb_clk);
    end
    check_all("tog_ready", 5'b00000, 3'd0, 0, 0, 0, 0, 1, 8'h00, 0, b);
    chk("tog_ready", "state", state_dbg, 1);
    guess("Y", 1, b);
    check_all("tog_newword", 5'b10001, 3'd0, 0, 0, 0, 0, 1, "Y", BUSY+1, b);

    // Randomized rounds against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) w[8*i +: 8] = 8'($urandom_range(65, 70));
      start_round(w);
      model_start(w);
      for (int g = 0; g < 14; g++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0: m = 8'h31;
            1: m = 8'h61;
            2: m = 8'h40;
            default: m = 8'h5B;
          endcase
        end else begin
          m = 8'($urandom_range(65, 72));
        end
        guess(m, 1 + $urandom_range(0, 2), b);
        model_guess(m, be);
        check_all($sformatf("rnd%0d_%0d", r, g), model_ic(), 3'(mmiss), mmis,
                  merr, mwin, mloss, !(mwin || mloss), mlet, be, b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
